// File: rtl/put_text_pkg.sv
// Shared text-memory definitions: default geometry, end-of-text byte, and the
// capture state encoding used by the text writer.
package text_pkg;

  localparam int TEXT_DATA_W      = 8;
  localparam int TEXT_ADDR_W      = 8;
  localparam int TEXT_END_ADDRESS = 255;

  localparam logic [7:0] EOT_CHAR = 8'h04;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

endpackage

// File: rtl/put_text.sv
// Text writer: captures a valid/ready byte stream into the text RAM write port
// at sequential addresses. Optional PUT_TEXT_EOT_EN ends capture on EOT_CHAR.
module put_text
  import text_pkg::*;
#(
  parameter int END_ADDRESS = TEXT_END_ADDRESS,
  parameter int ADDR_W      = TEXT_ADDR_W,
  parameter int DATA_W      = TEXT_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  output logic [ADDR_W:0]   byte_count,
  output logic              busy,
  output logic              done,
  output logic              full
);

  localparam logic [ADDR_W-1:0] END_PTR = ADDR_W'(END_ADDRESS);
  localparam logic [ADDR_W:0]   CNT_MAX = (ADDR_W + 1)'(END_ADDRESS + 1);

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic              accept;
  logic              eot_hit;

  // byte_count never exceeds the number of writable addresses
  function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] c);
    if (c >= CNT_MAX) return CNT_MAX;
    return c + 1'b1;
  endfunction

  assign in_ready = (state == CAPTURE) && !start && !stop;
  assign accept   = in_valid && in_ready;
  assign busy     = (state == CAPTURE);
  assign done     = (state == DONE);

`ifdef PUT_TEXT_EOT_EN
  assign eot_hit = (in_data == DATA_W'(EOT_CHAR));
`else
  assign eot_hit = 1'b0;
`endif

  // Write stage: the accepted beat reaches the RAM port one clock later
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_wren    <= 1'b0;
      mem_address <= '0;
      mem_data    <= '0;
    end else begin
      mem_wren <= accept;
      if (accept) begin
        mem_address <= wr_ptr;
        mem_data    <= in_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      byte_count <= '0;
      full       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= CAPTURE;
            wr_ptr     <= '0;
            byte_count <= '0;
            full       <= 1'b0;
          end
        end
        CAPTURE: begin
          if (start) begin
            wr_ptr     <= '0;
            byte_count <= '0;
            full       <= 1'b0;
          end else if (stop) begin
            state <= DONE;
          end else if (accept) begin
            byte_count <= sat_inc(byte_count);
            // pointer parks on the last address instead of wrapping
            if (wr_ptr == END_PTR) begin
              state <= DONE;
              full  <= 1'b1;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
              if (eot_hit) state <= DONE;
            end
          end
        end
        DONE: begin
          if (start) begin
            state      <= CAPTURE;
            wr_ptr     <= '0;
            byte_count <= '0;
            full       <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_put_text.sv
// Bench for put_text: vector table for the basic capture, hand sequences for
// fill, restart, start/stop collision, async reset and the optional EOT stop.
module tb_put_text;
  import text_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0, stop = 1'b0, in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, mem_wren, busy, done, full;
  logic [7:0] mem_address, mem_data;
  logic [8:0] byte_count;

  int errors = 0;
  int checks = 0;
  int writes_seen = 0;

  put_text dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
    .byte_count(byte_count), .busy(busy), .done(done), .full(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model of the capture behaviour, stepped on the same edges
  state_t      m_state;
  logic [7:0]  m_ptr;
  logic [8:0]  m_cnt;
  logic        m_full, m_acc, exp_wren;
  logic [15:0] sb[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_state = IDLE; m_ptr = 0; m_cnt = 0; m_full = 0; exp_wren = 0;
      sb.delete();
    end else begin
      m_acc = (m_state == CAPTURE) && !start && !stop && in_valid;
      exp_wren = m_acc;
      if (m_acc) sb.push_back({m_ptr, in_data});
      case (m_state)
        IDLE: if (start) begin m_state = CAPTURE; m_ptr = 0; m_cnt = 0; m_full = 0; end
        CAPTURE: begin
          if (start) begin m_ptr = 0; m_cnt = 0; m_full = 0; end
          else if (stop) m_state = DONE;
          else if (m_acc) begin
            m_cnt = m_cnt + 1;
            if (m_ptr == 8'd255) begin m_state = DONE; m_full = 1; end
            else m_ptr = m_ptr + 1;
`ifdef PUT_TEXT_EOT_EN
            if (in_data == 8'h04) m_state = DONE;
`endif
          end
        end
        DONE: if (start) begin m_state = CAPTURE; m_ptr = 0; m_cnt = 0; m_full = 0; end
        default: m_state = IDLE;
      endcase
    end
  end

  // Scoreboard: every RAM write must match the oldest expected beat
  always @(negedge clk) begin
    if (!reset) begin
      chk("sb_wren", mem_wren, exp_wren);
      if (mem_wren) begin
        writes_seen++;
        if (sb.size() == 0) chk("sb_unexpected_write", 1, 0);
        else begin
          logic [15:0] e;
          e = sb.pop_front();
          chk("sb_addr", mem_address, e[15:8]);
          chk("sb_data", mem_data, e[7:0]);
        end
      end
      chk("sb_count", byte_count, m_cnt);
      chk("sb_busy", busy, m_state == CAPTURE);
      chk("sb_done", done, m_state == DONE);
      chk("sb_full", full, m_full);
    end
  end

  task automatic step(input logic s, input logic p, input logic v, input logic [7:0] d);
    @(negedge clk);
    start = s; stop = p; in_valid = v; in_data = d;
  endtask

  typedef struct {
    logic st, sp, v; logic [7:0] d;
    logic rdy, wren; logic [7:0] addr, data;
    logic bsy, dn; logic [8:0] cnt;
  } vec_t;
  vec_t tbl[9];

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'd0, 8'h00, 1'b1, 1'b0, 9'd0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 8'h48, 1'b1, 1'b1, 8'd0, 8'h48, 1'b1, 1'b0, 9'd1};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 8'h65, 1'b1, 1'b1, 8'd1, 8'h65, 1'b1, 1'b0, 9'd2};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 8'h6C, 1'b1, 1'b1, 8'd2, 8'h6C, 1'b1, 1'b0, 9'd3};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 8'h6C, 1'b1, 1'b1, 8'd3, 8'h6C, 1'b1, 1'b0, 9'd4};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 8'h6F, 1'b1, 1'b1, 8'd4, 8'h6F, 1'b1, 1'b0, 9'd5};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'd4, 8'h6F, 1'b1, 1'b0, 9'd5};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 8'd4, 8'h6F, 1'b0, 1'b1, 9'd5};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 8'd4, 8'h6F, 1'b0, 1'b1, 9'd5};

    // Reset state
    #23;
    chk("rst_wren", mem_wren, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_data", mem_data, 0);
    chk("rst_count", byte_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_full", full, 0);
    chk("rst_ready", in_ready, 0);
    reset = 1'b0;

    // Basic "Hello" capture then stop
    for (int i = 0; i <= 9; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk("vec_wren", mem_wren, tbl[i-1].wren);
        chk("vec_addr", mem_address, tbl[i-1].addr);
        chk("vec_data", mem_data, tbl[i-1].data);
        chk("vec_busy", busy, tbl[i-1].bsy);
        chk("vec_done", done, tbl[i-1].dn);
        chk("vec_count", byte_count, tbl[i-1].cnt);
        chk("vec_full", full, 0);
      end
      if (i < 9) begin
        start = tbl[i].st; stop = tbl[i].sp; in_valid = tbl[i].v; in_data = tbl[i].d;
        #1 chk("vec_ready", in_ready, tbl[i].rdy);
      end
    end

    // Fill the whole buffer with a continuous stream
    step(1, 0, 0, 0);
    writes_seen = 0;
    for (int i = 0; i < 300; i++) begin
      step(0, 0, 1, 8'(i * 7 + 3));
      if (i == 255) #1 chk("fill_ready_last", in_ready, 1);
      if (i == 256) #1 chk("fill_ready_after", in_ready, 0);
    end
    step(0, 0, 0, 0);
    @(negedge clk);
    chk("fill_writes", writes_seen, 256);
    chk("fill_full", full, 1);
    chk("fill_count", byte_count, 256);
    chk("fill_done", done, 1);
    chk("fill_last_addr", mem_address, 255);

    // Restart mid-capture
    step(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 8'(8'h30 + i));
    step(1, 0, 1, 8'h55);
    #1 chk("restart_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 8'hAA);
    step(0, 0, 0, 0);
    @(negedge clk);
    chk("restart_count", byte_count, 3);
    chk("restart_addr", mem_address, 2);
    chk("restart_data", mem_data, 8'hAA);
    chk("restart_full", full, 0);

    // Toggling valid, then start and stop together
    step(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, i[0], 8'(8'h60 + i));
    step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    chk("collide_busy", busy, 1);
    chk("collide_done", done, 0);
    chk("collide_count", byte_count, 0);

    // Stop with nothing written
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    chk("empty_done", done, 1);
    chk("empty_count", byte_count, 0);

    // Async reset between acceptance and write
    step(1, 0, 0, 0);
    step(0, 0, 1, 8'h77);
    @(posedge clk);
    #2;
    chk("arst_wren_before", mem_wren, 1);
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("arst_wren", mem_wren, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_addr", mem_address, 0);
    chk("arst_data", mem_data, 0);
    chk("arst_count", byte_count, 0);
    chk("arst_full", full, 0);
    #1 reset = 1'b0;

    // End-of-text byte
    step(1, 0, 0, 0);
    step(0, 0, 1, 8'h41);
    step(0, 0, 1, 8'h04);
    step(0, 0, 1, 8'h42);
`ifdef PUT_TEXT_EOT_EN
    #1 chk("eot_ready", in_ready, 0);
`else
    #1 chk("eot_ready", in_ready, 1);
`endif
    step(0, 0, 0, 0);
    @(negedge clk);
`ifdef PUT_TEXT_EOT_EN
    chk("eot_count", byte_count, 2);
    chk("eot_done", done, 1);
    chk("eot_addr", mem_address, 1);
    chk("eot_data", mem_data, 8'h04);
`else
    chk("eot_count", byte_count, 3);
    chk("eot_busy", busy, 1);
    chk("eot_addr", mem_address, 2);
    chk("eot_data", mem_data, 8'h42);
`endif
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/put_text.md
Name: put_text

Overview:
- Writer end of the text-memory path.
- Accepts a stream of received/demodulated text bytes over a valid/ready handshake.
- Writes each byte into the single-port text RAM (the `ram` IP) at sequential addresses starting from 0.
- Stops when the buffer is full, on an explicit stop, or (optionally) on an end-of-text byte, so a reader can later replay the stored message.

Parameters:
- END_ADDRESS, 255, last writable RAM address; capture ends after the byte written here.
- ADDR_W, 8, RAM address width; END_ADDRESS must be < 2**ADDR_W.
- DATA_W, 8, text byte width.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  1-cycle pulse: begin a new capture from address 0 (also restarts a capture in progress).
- stop  in  1  1-cycle pulse: end the current capture.
- in_data  in  DATA_W  text byte offered.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts in_data this cycle (combinational).
- mem_address  out  ADDR_W  RAM address (registered).
- mem_data  out  DATA_W  RAM write data (registered).
- mem_wren  out  1  RAM write enable, 1-cycle strobe (registered).
- byte_count  out  ADDR_W+1  bytes written in the current/last capture.
- busy  out  1  state == CAPTURE.
- done  out  1  state == DONE.
- full  out  1  last capture ended by reaching END_ADDRESS.

Behaviour:
- Reset (async, active-high):
  - State = IDLE.
  - mem_address = 0, mem_data = 0, mem_wren = 0, byte_count = 0, full = 0.
  - Internal write pointer wr_ptr = 0.
- States:
  - IDLE: in_ready = 0. start -> CAPTURE, with wr_ptr = 0, byte_count = 0, full = 0.
  - CAPTURE: in_ready = !start && !stop.
    - Beat accepted when in_valid && in_ready.
    - Next cycle: mem_wren = 1, mem_address = wr_ptr, mem_data = in_data.
    - On the same edge: wr_ptr and byte_count increment.
    - Write latency: exactly 1 clock from acceptance.
  - DONE: in_ready = 0; outputs hold. start -> CAPTURE (clears wr_ptr, byte_count, full).
- CAPTURE -> DONE when:
  - a beat is accepted with wr_ptr == END_ADDRESS (full set to 1 on the same edge); or
  - stop is asserted (full stays 0).
- mem_wren is 0 on every cycle without an accepted beat in the previous cycle, in every state.
- Boundary conditions:
  - start and stop asserted together: start wins.
  - start during CAPTURE: the coinciding beat is not accepted (in_ready low); wr_ptr and byte_count clear; state stays CAPTURE.
  - stop with no bytes written: DONE, byte_count = 0.
  - wr_ptr never wraps; it is never incremented past END_ADDRESS. byte_count saturates at END_ADDRESS+1 (e.g., 256).
  - in_valid while not ready: ignored. The source must hold data; nothing is lost inside the block.
  - reset mid-capture: immediate return to IDLE. An in-flight mem_wren is deasserted asynchronously, and the RAM contents are undefined for that write.
- Arithmetic: wr_ptr is ADDR_W bits; byte_count is ADDR_W+1 bits, unsigned.

Optional Feature:
- Macro: PUT_TEXT_EOT_EN.
- When defined:
  - An accepted byte equal to EOT_CHAR (8'h04) is written like any other byte and counted.
  - The same edge moves CAPTURE -> DONE, with full = 0 unless that byte was also written at END_ADDRESS.
- When undefined: 8'h04 is ordinary data, and capture ends only on full or stop.

Decomposition:
- Shared package text_pkg holds:
  - TEXT_DATA_W = 8, TEXT_ADDR_W = 8, TEXT_END_ADDRESS = 255, EOT_CHAR = 8'h04.
  - State enum {IDLE, CAPTURE, DONE}.
- No sub-module. The `ram` IP is instantiated by the parent, which shares the RAM with the text reader; put_text only drives its write port.

Test Plan:
- Reset, start, then 5 beats 'H','e','l','l','o' (8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F), then stop -> mem_wren pulses one cycle after each beat at addresses 0..4 with matching data; done = 1, byte_count = 5, full = 0.
- Start, continuous in_valid for 300 cycles -> 256 writes at addresses 0..255; in_ready drops after the 256th acceptance; full = 1, byte_count = 256, no write at address 0 afterwards.
- Start, 10 beats, start again, 3 beats 8'hAA -> second capture writes addresses 0..2; byte_count = 3; the beat coinciding with the second start is not accepted.
- Start, beats with in_valid toggling every other cycle, then stop and start asserted in the same cycle -> start wins: state CAPTURE, byte_count = 0.
- Reset asserted mid-capture, between acceptance and write -> mem_wren = 0 immediately; state IDLE; all outputs return to reset values.
- With PUT_TEXT_EOT_EN: beats 8'h41, 8'h04, 8'h42 -> 8'h41 written at 0 and 8'h04 written at 1; DONE after 8'h04; 8'h42 not accepted; byte_count = 2. Without the macro: all three written, still busy.
